// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush control and operand-forward select generation for the five-stage MIPS pipeline.
// Optional macro HAZARD_FORWARD_EN enables forwarding selects and restricts operand stalls to load-use.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int REG_W     = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idIsMulDiv,
  input  logic             idReadsHiLo,
  input  logic             exRegWrite,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exDest,
  input  logic             memRegWrite,
  input  logic [REG_W-1:0] memDest,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             mdBusy,
  output logic [15:0]      stallCount,
  output logic [0:0]       mdState
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  logic [7:0] mdCnt;
  logic       exMatchRs, exMatchRt, memMatchRs, memMatchRt;
  logic       exHit, memHit, loadUse;
  logic       operandStall, mdStall, flush, stall, mdIssue;

  // $0 is hardwired zero, so it never creates a dependency.
  assign exMatchRs  = idUsesRs && exRegWrite  && (exDest  != '0) && (exDest  == idRs);
  assign exMatchRt  = idUsesRt && exRegWrite  && (exDest  != '0) && (exDest  == idRt);
  assign memMatchRs = idUsesRs && memRegWrite && (memDest != '0) && (memDest == idRs);
  assign memMatchRt = idUsesRt && memRegWrite && (memDest != '0) && (memDest == idRt);

  assign exHit   = exMatchRs || exMatchRt;
  assign memHit  = memMatchRs || memMatchRt;
  assign loadUse = exMemRead && exHit;

`ifdef HAZARD_FORWARD_EN
  assign operandStall = loadUse;

  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (exMatchRs)       forwardA = 2'b10;
    else if (memMatchRs) forwardA = 2'b01;
    if (exMatchRt)       forwardB = 2'b10;
    else if (memMatchRt) forwardB = 2'b01;
  end
`else
  // Without bypass paths every in-flight producer must drain; a load is just an EX producer.
  assign operandStall = loadUse || exHit || memHit;
  assign forwardA     = 2'b00;
  assign forwardB     = 2'b00;
`endif

  assign mdBusy  = (mdCnt != 8'd0);
  assign mdState = mdBusy ? MD_BUSY : RUN;
  assign mdStall = mdBusy && (idIsMulDiv || idReadsHiLo);

  // A taken branch overrides every stall: the ID instruction is discarded anyway.
  assign flush   = branchTaken;
  assign stall   = !flush && (operandStall || mdStall);
  assign mdIssue = idIsMulDiv && !stall && !flush;

  assign pcWrite    = !stall;
  assign ifIdWrite  = !stall;
  assign ifIdFlush  = flush;
  assign idExBubble = flush || stall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mdCnt <= 8'd0;
    end else if (mdIssue) begin
      mdCnt <= 8'(MD_CYCLES);
    end else if (mdCnt != 8'd0) begin
      mdCnt <= mdCnt - 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCount <= 16'd0;
    end else if (!pcWrite && (stallCount != 16'hFFFF)) begin
      stallCount <= stallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZARD_FORWARD_EN when it is defined.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       Clk, Reset;
  logic [4:0] idRs, idRt, exDest, memDest;
  logic       idUsesRs, idUsesRt, idIsMulDiv, idReadsHiLo;
  logic       exRegWrite, exMemRead, memRegWrite, branchTaken;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdBusy;
  logic [1:0] forwardA, forwardB;
  logic [15:0] stallCount;
  logic [0:0] mdState;

  int tests = 0;
  int failed = 0;
  logic [15:0] expStall;

  pipeline_hazard_ctrl #(.MD_CYCLES(4), .REG_W(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idIsMulDiv(idIsMulDiv), .idReadsHiLo(idReadsHiLo),
    .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exDest(exDest),
    .memRegWrite(memRegWrite), .memDest(memDest), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExBubble(idExBubble), .forwardA(forwardA), .forwardB(forwardB),
    .mdBusy(mdBusy), .stallCount(stallCount), .mdState(mdState)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idRs = '0; idRt = '0; idUsesRs = 0; idUsesRt = 0;
    idIsMulDiv = 0; idReadsHiLo = 0;
    exRegWrite = 0; exMemRead = 0; exDest = '0;
    memRegWrite = 0; memDest = '0; branchTaken = 0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_pcWrite"},   16'(pcWrite),    16'd1);
    chk({tag, "_ifIdWrite"}, 16'(ifIdWrite),  16'd1);
    chk({tag, "_ifIdFlush"}, 16'(ifIdFlush),  16'd0);
    chk({tag, "_bubble"},    16'(idExBubble), 16'd0);
    chk({tag, "_fwdA"},      16'(forwardA),   16'd0);
    chk({tag, "_fwdB"},      16'(forwardB),   16'd0);
    chk({tag, "_mdBusy"},    16'(mdBusy),     16'd0);
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    #2;
    chkIdleOutputs("rst");
    chk("rst_stallCount", stallCount, 16'd0);
    cyc();
    Reset = 1'b0;
    #2;
    chkIdleOutputs("idle");
    chk("idle_stallCount", stallCount, 16'd0);
    expStall = 16'd0;

    // load-use on rs: load in EX
    cyc();
    exRegWrite = 1; exMemRead = 1; exDest = 5'd8; idRs = 5'd8; idUsesRs = 1;
    #2;
    chk("lu1_pcWrite", 16'(pcWrite), 16'd0);
    chk("lu1_ifIdWrite", 16'(ifIdWrite), 16'd0);
    chk("lu1_bubble", 16'(idExBubble), 16'd1);
    expStall = expStall + 16'd1;
    // load moves to MEM, bubble in EX
    cyc();
    exRegWrite = 0; exMemRead = 0; exDest = '0; memRegWrite = 1; memDest = 5'd8;
    #2;
    chk("lu2_stallCount", stallCount, expStall);
    chk("lu2_pcWrite", 16'(pcWrite), FWD ? 16'd1 : 16'd0);
    chk("lu2_fwdA", 16'(forwardA), FWD ? 16'd1 : 16'd0);
    if (!FWD) expStall = expStall + 16'd1;
    // load retired to WB
    cyc();
    memRegWrite = 0; memDest = '0;
    #2;
    chk("lu3_pcWrite", 16'(pcWrite), 16'd1);
    chk("lu3_stallCount", stallCount, expStall);

    // ALU producer in EX feeding rt
    cyc();
    idle();
    exRegWrite = 1; exDest = 5'd9; idRt = 5'd9; idUsesRt = 1;
    #2;
    chk("alu_fwdB", 16'(forwardB), FWD ? 16'd2 : 16'd0);
    chk("alu_pcWrite", 16'(pcWrite), FWD ? 16'd1 : 16'd0);
    if (!FWD) expStall = expStall + 16'd1;

    // $0 never matches in any stage
    cyc();
    idle();
    exRegWrite = 1; exDest = '0; memRegWrite = 1; memDest = '0;
    idRs = '0; idRt = '0; idUsesRs = 1; idUsesRt = 1;
    #2;
    chk("zero_stallCount", stallCount, expStall);
    chk("zero_fwdA", 16'(forwardA), 16'd0);
    chk("zero_fwdB", 16'(forwardB), 16'd0);
    chk("zero_pcWrite", 16'(pcWrite), 16'd1);

    // match ignored when the source is not really read
    cyc();
    idle();
    exRegWrite = 1; exMemRead = 1; exDest = 5'd5; idRs = 5'd5; idUsesRs = 0;
    #2;
    chk("nouse_pcWrite", 16'(pcWrite), 16'd1);
    chk("nouse_fwdA", 16'(forwardA), 16'd0);

    // EX wins over MEM on rs; MEM-only on rt
    cyc();
    idle();
    exRegWrite = 1; exDest = 5'd7; memRegWrite = 1; memDest = 5'd7;
    idRs = 5'd7; idUsesRs = 1;
    #2;
    chk("prio_fwdA", 16'(forwardA), FWD ? 16'd2 : 16'd0);
    chk("prio_pcWrite", 16'(pcWrite), FWD ? 16'd1 : 16'd0);
    if (!FWD) expStall = expStall + 16'd1;
    cyc();
    idle();
    memRegWrite = 1; memDest = 5'd12; idRt = 5'd12; idUsesRt = 1;
    #2;
    chk("memrt_fwdB", 16'(forwardB), FWD ? 16'd1 : 16'd0);
    chk("memrt_pcWrite", 16'(pcWrite), FWD ? 16'd1 : 16'd0);
    if (!FWD) expStall = expStall + 16'd1;

    // branch taken together with load-use: flush wins, no stall
    cyc();
    idle();
    branchTaken = 1; exRegWrite = 1; exMemRead = 1; exDest = 5'd8; idRs = 5'd8; idUsesRs = 1;
    #2;
    chk("br_stallCount_before", stallCount, expStall);
    chk("br_flush", 16'(ifIdFlush), 16'd1);
    chk("br_bubble", 16'(idExBubble), 16'd1);
    chk("br_pcWrite", 16'(pcWrite), 16'd1);
    chk("br_ifIdWrite", 16'(ifIdWrite), 16'd1);

    // branch taken while mult is in ID: not issued
    cyc();
    chk("br_stallCount", stallCount, expStall);
    idle();
    branchTaken = 1; idIsMulDiv = 1;
    #2;
    chk("brmd_pcWrite", 16'(pcWrite), 16'd1);
    cyc();
    idle();
    #2;
    chk("brmd_mdBusy", 16'(mdBusy), 16'd0);
    chk("brmd_mdState", 16'(mdState), 16'd0);

    // div issue then mflo: stalled exactly 4 cycles
    cyc();
    idIsMulDiv = 1;
    #2;
    chk("div_issue_pcWrite", 16'(pcWrite), 16'd1);
    chk("div_issue_mdBusy", 16'(mdBusy), 16'd0);
    cyc();
    idle();
    idReadsHiLo = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("mflo_busy%0d", i), 16'(mdBusy), 16'd1);
      chk($sformatf("mflo_state%0d", i), 16'(mdState), 16'd1);
      chk($sformatf("mflo_pcWrite%0d", i), 16'(pcWrite), 16'd0);
      chk($sformatf("mflo_bubble%0d", i), 16'(idExBubble), 16'd1);
      expStall = expStall + 16'd1;
      cyc();
    end
    #2;
    chk("mflo_done_busy", 16'(mdBusy), 16'd0);
    chk("mflo_done_pcWrite", 16'(pcWrite), 16'd1);
    chk("mflo_stallCount", stallCount, expStall);

    // reset asserted while busy
    cyc();
    idle();
    idIsMulDiv = 1;
    cyc();
    idle();
    idReadsHiLo = 1;
    cyc();
    cyc();
    #2;
    chk("mid_busy_pre", 16'(mdBusy), 16'd1);
    idle();
    Reset = 1'b1;
    #1;
    chk("mid_rst_mdBusy", 16'(mdBusy), 16'd0);
    chk("mid_rst_stallCount", stallCount, 16'd0);
    chk("mid_rst_pcWrite", 16'(pcWrite), 16'd1);
    cyc();
    Reset = 1'b0;
    cyc();
    #2;
    chkIdleOutputs("post");
    chk("post_stallCount", stallCount, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control unit for the five-stage MIPS core. It inspects the instruction sitting in decode and the instructions in EX and MEM, then drives the PC, IF/ID and ID/EX control lines. It covers load-use and RAW stalls, taken-branch flushes and occupancy of the multi-cycle multiply/divide unit. It sits beside `decodeState` and produces operand-forwarding selects that travel down the ID/EX register.

## Interface
- `MD_CYCLES`, 32: busy cycles of mult/div after issue (2..255)
- `REG_W`, 5: register specifier width
- `Clk`  in  1  pipeline clock, rising edge
- `Reset`  in  1  asynchronous, active-high
- `idRs`, `idRt`  in  REG_W each  source specifiers of the instruction in ID
- `idUsesRs`, `idUsesRt`  in  1 each  the ID instruction really reads that source
- `idIsMulDiv`  in  1  ID holds mult/multu/div/divu
- `idReadsHiLo`  in  1  ID holds mfhi/mflo
- `exRegWrite`, `exMemRead`  in  1 each  control bits of the instruction in EX
- `exDest`  in  REG_W  destination of the instruction in EX
- `memRegWrite`  in  1  control bit of the instruction in MEM
- `memDest`  in  REG_W  destination of the instruction in MEM
- `branchTaken`  in  1  branch/jump resolved taken in EX this cycle
- `pcWrite`  out  1  PC update enable
- `ifIdWrite`  out  1  IF/ID load enable
- `ifIdFlush`  out  1  IF/ID clear to nop
- `idExBubble`  out  1  load zeros into ID/EX control field
- `forwardA`, `forwardB`  out  2 each  operand source for the ID instruction once it is in EX: 00 regfile, 10 EX/MEM, 01 MEM/WB
- `mdBusy`  out  1  mult/div unit occupied
- `stallCount`  out  16  saturating count of stall cycles

## Operation
- Register match rule: `X` matches stage `S` when `S` has RegWrite, `SDest != 0` and `SDest == X`. The match is qualified by the matching `idUses*` bit.
- Write-back to decode needs no handling. The register file writes early and reads late in the same cycle.
- Two states, held in a registered counter `mdCnt` (8 bits):
  - RUN: `mdCnt == 0`
  - MD_BUSY: `mdCnt != 0`
- Event priority, highest first:
  1. `branchTaken` (flush)
  2. operand stall
  3. mult/div stall
- Flush: `ifIdFlush = 1`, `idExBubble = 1`, `pcWrite = 1`, `ifIdWrite = 1`. All stalls are suppressed. A mult/div in ID is not issued.
- Operand stall (see Configuration for when it fires): `pcWrite = 0`, `ifIdWrite = 0`, `idExBubble = 1`.
- Mult/div stall, condition `mdBusy && (idIsMulDiv || idReadsHiLo)`: same outputs as an operand stall.
- Mult/div issue: `idIsMulDiv`, no stall and no flush in that cycle. On the next edge `mdCnt` loads `MD_CYCLES`.
- In MD_BUSY, `mdCnt` decrements each cycle and reaches RUN after `MD_CYCLES` cycles. `mdBusy` is 1 whenever `mdCnt != 0`.
- `stallCount` increments on every cycle with `pcWrite == 0`. It saturates at 0xFFFF.
- Forwarding:
  - If `idRs` matches EX, `forwardA = 10`.
  - Else if `idRs` matches MEM, `forwardA = 01`.
  - Else `forwardA = 00`.
  - `forwardB` uses `idRt` with the same rule.
  - The selects are valid only when ID is not stalled or flushed.

## Timing
- All control outputs are combinational from the current inputs and `mdCnt`. No added latency.
- `mdCnt` and `stallCount` update on the rising edge of `Clk`.
- Reset clears `mdCnt` and `stallCount` immediately, including mid-MD_BUSY.
- With idle inputs after reset: `pcWrite = 1`, `ifIdWrite = 1`, `ifIdFlush = 0`, `idExBubble = 0`, `forwardA = forwardB = 00`, `mdBusy = 0`, `stallCount = 0`.
- Load-use with forwarding costs exactly 1 stall cycle. The next cycle the load is in MEM and `forward = 01`.
- Issue while MD_BUSY cannot happen, because any mult/div in ID stalls while busy.
- In the last busy cycle (`mdCnt == 1`) the stall still applies. The dependent instruction proceeds the cycle after.
- Register `$0` never matches, never stalls and never forwards.

## Configuration
- Macro: `HAZARD_FORWARD_EN`.
- Defined:
  - Forwarding selects are active.
  - Operand stall fires only for load-use: `exMemRead` together with an EX match.
- Undefined:
  - `forwardA` and `forwardB` are tied to 00.
  - Operand stall fires on any EX match or MEM match.
  - A dependency on EX costs 2 stall cycles; a dependency on MEM costs 1.

## Test plan
- Reset asserted mid-busy, 5 cycles after a `div` issue → `mdBusy = 0` and `stallCount = 0` immediately; `pcWrite = 1` with idle inputs.
- `exMemRead = 1`, `exDest = 8`, `idRs = 8`, `idUsesRs = 1`:
  - with forwarding → 1 cycle of `pcWrite = 0` and `idExBubble = 1`, then `forwardA = 01`, and `stallCount = 1`.
  - without forwarding → 2 stall cycles.
- `exRegWrite = 1`, `exDest = 9`, `idRt = 9` (forwarding on) → `forwardB = 10`, no stall. With `exDest = 0`, `idRt = 0` → `forwardB = 00`.
- `div` issued with `MD_CYCLES = 4`, followed by `mflo` → `mflo` stalled 4 cycles; `mdBusy` high for exactly 4 cycles; `stallCount = 4`.
- `branchTaken = 1` together with a load-use match → `ifIdFlush = 1`, `idExBubble = 1`, `pcWrite = 1`; no stall is counted.
- `branchTaken = 1` while `mult` is in ID → no issue; `mdBusy` stays 0.
